// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg
//   Shared types, constants and the round-robin pick function for the
//   multi-requester UART transmitter (uart_tx_arbiter / uart_rr_arbiter).
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

   localparam int UART_DATA_BITS = 8;
   localparam int UART_MIN_DIV   = 2;
   localparam int MAX_REQ        = 8;

   // One-hot grant to the first valid requester found searching upward from
   // ptr, wrapping at num_req. Bits at or above num_req are ignored.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [2:0]         ptr,
                                                  input int                 num_req);
      logic [MAX_REQ-1:0] grant;
      logic               found;
      int                 idx;
      grant = '0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % num_req;
         if (k < num_req && !found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter
//   Combinational round-robin grant plus the registered search pointer.
//   Ports:
//     clk, resetn  clock and synchronous active-low reset
//     req_valid    per-requester valid
//     enable       grant allowed this cycle (transmitter idle)
//     grant        one-hot grant (doubles as req_ready)
//     grant_idx    binary index of the granted requester
//     xfer         a transfer happens on the coming edge
module uart_rr_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 2
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [2:0]         grant_idx,
   output logic               xfer
);

   logic [2:0]         ptr_reg, ptr_next;
   logic [MAX_REQ-1:0] valid_ext;
   logic [MAX_REQ-1:0] pick;

   // Zero-extend the valid vector to the fixed width of rr_pick.
   genvar gi;
   generate
      for (gi = 0; gi < MAX_REQ; gi++) begin : g_ext
         if (gi < NUM_REQ) begin : g_used
            assign valid_ext[gi] = req_valid[gi];
         end else begin : g_unused
            assign valid_ext[gi] = 1'b0;
         end
      end
   endgenerate

   assign pick  = rr_pick(valid_ext, ptr_reg, NUM_REQ);
   assign grant = enable ? pick[NUM_REQ-1:0] : '0;
   assign xfer  = |grant;

   always_comb begin
      grant_idx = 3'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) grant_idx = 3'(i);
      end
   end

   // Pointer moves past the winner only on an actual transfer; a requester
   // dropping valid without being served leaves it untouched.
   assign ptr_next = (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr_reg <= 3'd0;
      end else if (xfer) begin
         ptr_reg <= ptr_next;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin shares one 8N1 UART transmit line between NUM_REQ byte
//   requesters. Bit period comes from a run-time divider register.
//   Ports:
//     clk, resetn         clock and synchronous active-low reset
//     req_valid/req_data  per-requester byte interface (byte i at [8i+7:8i])
//     req_ready           one-hot accept, only while idle
//     cfg_div_we/di/do    divider register write strobe, data, readback
//     ser_tx              registered serial output, idles high
//     busy                frame in progress
//     grant_id            requester of current / last frame
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ   = 2,
   parameter int DIV_RESET = 106,
   parameter int DIV_W     = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   input  logic                 cfg_div_we,
   input  logic [DIV_W-1:0]     cfg_div_di,
   output logic [DIV_W-1:0]     cfg_div_do,
   output logic                 ser_tx,
   output logic                 busy,
   output logic [2:0]           grant_id
);

   tx_state_t        state_reg, state_next;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] div_eff;
   logic [DIV_W-1:0] div_lat_reg, div_lat_next;
   logic [DIV_W-1:0] cnt_reg, cnt_next;
   logic [2:0]       bit_idx_reg, bit_idx_next;
   logic [2:0]       grant_id_reg, grant_id_next;
   logic [7:0]       data_reg, data_next;
   logic             ser_tx_reg, ser_tx_next;
   logic [2:0]       win_idx;
   logic [7:0]       win_data;
   logic             xfer;
   logic             arb_en;
   logic             bit_done;

   // Held in reset, the block must not advertise ready.
   assign arb_en = (state_reg == IDLE) && resetn;

   uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .clk       (clk),
      .resetn    (resetn),
      .req_valid (req_valid),
      .enable    (arb_en),
      .grant     (req_ready),
      .grant_idx (win_idx),
      .xfer      (xfer)
   );

   always_comb begin
      win_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == 3'(i)) win_data = req_data[8*i +: 8];
      end
   end

   // Divider register; a frame starting on the same edge as a write latches
   // the old value because div_eff is derived from the pre-edge register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         div_reg <= DIV_W'(DIV_RESET);
      end else if (cfg_div_we) begin
         div_reg <= cfg_div_di;
      end
   end

   assign div_eff    = (div_reg < DIV_W'(UART_MIN_DIV)) ? DIV_W'(UART_MIN_DIV) : div_reg;
   assign cfg_div_do = div_reg;
   assign bit_done   = (cnt_reg == '0);

   // State register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg    <= IDLE;
         cnt_reg      <= '0;
         bit_idx_reg  <= 3'd0;
         data_reg     <= 8'h00;
         div_lat_reg  <= DIV_W'(DIV_RESET);
         grant_id_reg <= 3'd0;
         ser_tx_reg   <= 1'b1;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         bit_idx_reg  <= bit_idx_next;
         data_reg     <= data_next;
         div_lat_reg  <= div_lat_next;
         grant_id_reg <= grant_id_next;
         ser_tx_reg   <= ser_tx_next;
      end
   end

   // Next-state logic; the bit-period counter runs div-1 down to 0.
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      bit_idx_next  = bit_idx_reg;
      data_next     = data_reg;
      div_lat_next  = div_lat_reg;
      grant_id_next = grant_id_reg;
      case (state_reg)
         IDLE: begin
            if (xfer) begin
               state_next    = START;
               data_next     = win_data;
               grant_id_next = win_idx;
               div_lat_next  = div_eff;
               cnt_next      = div_eff - DIV_W'(1);
               bit_idx_next  = 3'd0;
            end
         end
         START: begin
            if (bit_done) begin
               state_next = DATA;
               cnt_next   = div_lat_reg - DIV_W'(1);
            end else begin
               cnt_next = cnt_reg - DIV_W'(1);
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_next = div_lat_reg - DIV_W'(1);
               if (bit_idx_reg == 3'(UART_DATA_BITS - 1)) begin
                  state_next = STOP;
               end else begin
                  bit_idx_next = bit_idx_reg + 3'd1;
               end
            end else begin
               cnt_next = cnt_reg - DIV_W'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               state_next = IDLE;
            end else begin
               cnt_next = cnt_reg - DIV_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Output logic; ser_tx is precomputed from the next state and registered.
   always_comb begin
      ser_tx_next = 1'b1;
      case (state_next)
         START:   ser_tx_next = 1'b0;
         DATA:    ser_tx_next = data_next[bit_idx_next];
         default: ser_tx_next = 1'b1;
      endcase
   end

   assign ser_tx   = ser_tx_reg;
   assign busy     = (state_reg != IDLE);
   assign grant_id = grant_id_reg;

endmodule
